// File: rtl/linebuf_pkg.sv
// Shared types and sizing helpers for the line-buffer sequencer and its raster counters.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package linebuf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } lb_state_t;

   localparam int IMG_W_DEF = 5;
   localparam int IMG_H_DEF = 5;
   localparam int K_DEF     = 3;

   // Counter width for a range of n positions; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Number of fully in-image KxK windows in a w x h frame.
   function automatic int num_win(input int w, input int h, input int k);
      return (h - k + 1) * (w - k + 1);
   endfunction

   localparam int NUM_WIN = num_win(IMG_W_DEF, IMG_H_DEF, K_DEF);

endpackage

// File: rtl/linebuf_raster_cnt.sv
// Raster column/row position counter with clear, enable and wrap flags.
// Latency: position updates on the clock edge after en/clr; flags are combinational from position.
// Backpressure: none; the owner gates en with its own handshake.
module raster_cnt #(
   parameter int W  = 5,
   parameter int H  = 5,
   parameter int CW = 3,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] col,
   output logic [RW-1:0] row,
   output logic          col_last,
   output logic          frame_last
);

   assign col_last   = (col == CW'(W - 1));
   assign frame_last = col_last && (row == RW'(H - 1));

   // Advance one pixel per enable; wrap the column each line and both at end of frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col_last) begin
            col <= '0;
            row <= frame_last ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/linebuf_ctrl.sv
// Sequencer for the rowbuf chain and KxK window registers: shift enable, position and window-valid flag.
// Latency: shift_en is combinational with the input handshake; win_valid follows the completing accept by 1 cycle.
// Backpressure: an unconsumed window drops in_ready so the window registers never shift under it.
module linebuf_ctrl
   import linebuf_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int K     = K_DEF,
   parameter int CW    = cnt_w(IMG_W),
   parameter int RW    = cnt_w(IMG_H)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          shift_en,
   output logic          win_valid,
   input  logic          win_ready,
   output logic [RW-1:0] win_row,
   output logic [CW-1:0] win_col,
   output logic          busy,
   output logic          frame_done
);

   lb_state_t     state, state_nxt;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          col_last, frame_last;
   logic          last_px;
   logic          in_win;
   logic          cnt_clr;

   assign in_ready   = (state == RUN) && (!win_valid || win_ready);
   assign shift_en   = in_valid && in_ready;
   assign busy       = (state != IDLE);
   assign frame_done = (state == DONE);
   assign cnt_clr    = (state == IDLE) && start;
   assign last_px    = col_last && frame_last;
   // Bottom-right corner of a KxK window has just arrived; guards the offset subtraction.
   assign in_win     = (row >= RW'(K - 1)) && (col >= CW'(K - 1));

   raster_cnt #(
      .W  (IMG_W),
      .H  (IMG_H),
      .CW (CW),
      .RW (RW)
   ) u_pos (
      .clk        (clk),
      .rst        (rst),
      .en         (shift_en),
      .clr        (cnt_clr),
      .col        (col),
      .row        (row),
      .col_last   (col_last),
      .frame_last (frame_last)
   );

   // Frame sequencing: wait for start, stream a frame, flush the last window, pulse done.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (shift_en && last_px) state_nxt = DRAIN;
         DRAIN:   if (!win_valid || win_ready) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Window flag: set with the top-left coordinate on a completing accept, clear on consume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
      end else if (shift_en && in_win) begin
         win_valid <= 1'b1;
         win_row   <= row - RW'(K - 1);
         win_col   <= col - CW'(K - 1);
      end else if (win_ready) begin
         win_valid <= 1'b0;
      end
   end

endmodule
